stream_downsizer: RTL and testbench
===================================

STREAM_DOWNSIZER -- requirements
Module: stream_downsizer

Interface
REQ-001 Parameter DATA_BITS, default 32, input word width in bits.
REQ-002 Parameter OUT_BITS, default 8, output slice width; DATA_BITS SHALL be an integer multiple of OUT_BITS with RATIO = DATA_BITS/OUT_BITS >= 2; elaboration SHALL fail otherwise.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 saxis_tdata  input  DATA_BITS  input word; connects directly to the FIFO stage's maxis_tdata.
REQ-006 saxis_tvalid  input  1  input word valid.
REQ-007 saxis_tready  output  1  input word accepted when high together with saxis_tvalid.
REQ-008 maxis_tdata  output  OUT_BITS  output slice.
REQ-009 maxis_tvalid  output  1  output slice valid.
REQ-010 maxis_tready  input  1  downstream accepts the slice.
REQ-011 maxis_tlast  output  1  high on the final slice of each input word.
REQ-012 words_accepted  output  32  input handshake count; present only with STREAM_DOWNSIZER_STATS_EN.
REQ-013 slices_sent  output  32  output handshake count; present only with STREAM_DOWNSIZER_STATS_EN.

Function
REQ-014 Held state: word register (DATA_BITS), slice index (clog2(RATIO) bits), full flag; states EMPTY (full=0) and SHIFT (full=1).
REQ-015 Output: maxis_tvalid = full; maxis_tdata = word[index*OUT_BITS +: OUT_BITS]; slices leave LSB first.
REQ-016 maxis_tlast = full && index == RATIO-1.
REQ-017 saxis_tready = !reset && (!full || (maxis_tlast && maxis_tready)); combinational, so the last slice and the next word transfer in the same cycle.
REQ-018 EMPTY + input handshake -> SHIFT; word loaded, index 0; first slice valid on the next cycle (1-cycle latency).
REQ-019 SHIFT + output handshake, index < RATIO-1 -> index+1; no other state changes.
REQ-020 SHIFT + output handshake on last slice, no input handshake -> EMPTY.
REQ-021 SHIFT + output handshake on last slice + simultaneous input handshake -> stay in SHIFT; new word loaded, index 0; zero bubble cycles, full output rate sustained.
REQ-022 maxis_tvalid high and maxis_tready low -> maxis_tdata and maxis_tlast SHALL hold stable; maxis_tvalid SHALL NOT deassert before the handshake.
REQ-023 saxis_tdata is sampled only on an input handshake; saxis_tvalid without saxis_tready SHALL NOT change state.

Reset
REQ-024 reset high at a rising edge -> full=0, index=0, word=0, counters=0; maxis_tvalid=0, maxis_tlast=0, maxis_tdata=0 from the next cycle.
REQ-025 saxis_tready SHALL be 0 in every cycle where reset is high.
REQ-026 Reset in mid-word discards the remaining slices; no partial slice SHALL be emitted after reset deasserts.

Configuration
REQ-027 With macro STREAM_DOWNSIZER_STATS_EN defined, words_accepted and slices_sent SHALL each increment by 1 on their handshake, wrap modulo 2^32, and clear on reset.
REQ-028 Without STREAM_DOWNSIZER_STATS_EN, the counter ports and logic SHALL be absent; all other behaviour is identical.

Structure
REQ-029 Width-check helper and the RATIO/index-width derivation SHALL be placed in shared package stream_util_pkg, for reuse by the matching upsizer.
REQ-030 No sub-module; a single flat module, with the stats counters inline under the macro.

Verification
REQ-031 Reset held 4 cycles, then released -> maxis_tvalid=0 and saxis_tready=0 during reset; saxis_tready=1 on the first cycle after release.
REQ-032 Single word 0x44332211 with maxis_tready=1 -> slices 0x11,0x22,0x33,0x44 on 4 consecutive cycles starting 1 cycle after accept; tlast only on 0x44.
REQ-033 Back-to-back words 0xA3A2A1A0 and 0xB3B2B1B0, maxis_tready=1 -> 8 slices in 8 consecutive cycles with no bubble; second word accepted in the same cycle as 0xA3.
REQ-034 maxis_tready=0 for 3 cycles while 0x22 is presented -> 0x22 and tlast=0 held stable; saxis_tready=0 throughout the stall.
REQ-035 Reset asserted after slice 0x22 is accepted -> no 0x33 or 0x44 emitted; the next word starts at its own LSB slice.
REQ-036 FIFO stage plus downsizer chained, 1000 random words, random 0-2 cycle gaps on both sides -> byte stream matches the LSB-first expansion exactly; with STREAM_DOWNSIZER_STATS_EN, words_accepted=1000 and slices_sent=4000.

Source files
------------

// File: rtl/stream_util_pkg.sv
// Shared width helpers for the stream width converters (downsizer and upsizer).
// Holds the legality check for the wide/narrow width pair and derives the
// width ratio and the slice-index width from it.
package stream_util_pkg;

  // Wide side must be a whole multiple of the narrow side, at least twice as wide.
  function automatic bit width_ok(input int wide_bits, input int narrow_bits);
    return (narrow_bits > 0) && (wide_bits % narrow_bits == 0) &&
           (wide_bits / narrow_bits >= 2);
  endfunction

  // Number of narrow slices per wide word; guarded so a bad pair still elaborates
  // far enough to reach the width check.
  function automatic int width_ratio(input int wide_bits, input int narrow_bits);
    return (narrow_bits > 0) ? wide_bits / narrow_bits : 2;
  endfunction

  // Bits needed to index one slice out of `ratio` slices (never below 1).
  function automatic int index_width(input int ratio);
    return (ratio > 2) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/stream_downsizer.sv
// AXI-Stream style width downsizer: each DATA_BITS input word is emitted as
// DATA_BITS/OUT_BITS output slices, least-significant slice first, with tlast
// marking the final slice of every word. The next word is taken in the same
// cycle as the last slice leaves, so full output rate is sustained.
// Optional handshake counters are built when STREAM_DOWNSIZER_STATS_EN is defined.
module stream_downsizer
  import stream_util_pkg::*;
#(
  parameter int DATA_BITS = 32,
  parameter int OUT_BITS  = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] saxis_tdata,
  input  logic                 saxis_tvalid,
  output logic                 saxis_tready,
  output logic [OUT_BITS-1:0]  maxis_tdata,
  output logic                 maxis_tvalid,
  input  logic                 maxis_tready,
  output logic                 maxis_tlast
`ifdef STREAM_DOWNSIZER_STATS_EN
  ,
  output logic [31:0]          words_accepted,
  output logic [31:0]          slices_sent
`endif
);

  localparam int RATIO = width_ratio(DATA_BITS, OUT_BITS);
  localparam int IDX_W = index_width(RATIO);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  generate
    if (!width_ok(DATA_BITS, OUT_BITS)) begin : g_width_err
      $error("stream_downsizer: DATA_BITS must be a multiple of OUT_BITS with ratio >= 2");
    end
  endgenerate

  logic [DATA_BITS-1:0] word_q, word_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 full_q, full_d;
  logic [OUT_BITS-1:0]  slice;
  logic                 last_slice;
  logic                 in_hs;
  logic                 out_hs;

  assign last_slice   = full_q && (idx_q == LAST_IDX);
  assign saxis_tready = !reset && (!full_q || (last_slice && maxis_tready));
  assign in_hs        = saxis_tvalid && saxis_tready;
  assign out_hs       = full_q && maxis_tready;

  assign maxis_tvalid = full_q;
  assign maxis_tlast  = last_slice;
  assign maxis_tdata  = slice;

  // Select the slice addressed by the index (slice 0 is the LSBs of the word).
  always_comb begin
    slice = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (idx_q == IDX_W'(i)) slice = word_q[i*OUT_BITS +: OUT_BITS];
    end
  end

  // Next state: a new word always restarts at slice 0, otherwise step or drain.
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    full_d = full_q;
    if (in_hs) begin
      word_d = saxis_tdata;
      idx_d  = '0;
      full_d = 1'b1;
    end else if (out_hs) begin
      if (idx_q == LAST_IDX) begin
        idx_d  = '0;
        full_d = 1'b0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // Word register, slice index and full flag; reset drops any partial word.
  always_ff @(posedge clock) begin
    if (reset) begin
      word_q <= '0;
      idx_q  <= '0;
      full_q <= 1'b0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
      full_q <= full_d;
    end
  end

`ifdef STREAM_DOWNSIZER_STATS_EN
  logic [31:0] words_q;
  logic [31:0] slices_q;

  // Free-running handshake counters, wrapping modulo 2^32.
  always_ff @(posedge clock) begin
    if (reset) begin
      words_q  <= '0;
      slices_q <= '0;
    end else begin
      if (in_hs)  words_q  <= words_q + 32'd1;
      if (out_hs) slices_q <= slices_q + 32'd1;
    end
  end

  assign words_accepted = words_q;
  assign slices_sent    = slices_q;
`endif

endmodule

// File: tb/tb_stream_downsizer.sv
// Testbench for stream_downsizer: directed timing scenarios followed by a long
// randomized run, with expected slices tracked in a scoreboard queue.
module tb_stream_downsizer;

  localparam int DATA_BITS = 32;
  localparam int OUT_BITS  = 8;
  localparam int RATIO     = DATA_BITS / OUT_BITS;
  localparam int N_RAND    = 1000;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [DATA_BITS-1:0] saxis_tdata;
  logic                 saxis_tvalid;
  logic                 saxis_tready;
  logic [OUT_BITS-1:0]  maxis_tdata;
  logic                 maxis_tvalid;
  logic                 maxis_tready;
  logic                 maxis_tlast;
`ifdef STREAM_DOWNSIZER_STATS_EN
  logic [31:0]          words_accepted;
  logic [31:0]          slices_sent;
`endif

  stream_downsizer #(.DATA_BITS(DATA_BITS), .OUT_BITS(OUT_BITS)) dut (
    .clock        (clock),
    .reset        (reset),
    .saxis_tdata  (saxis_tdata),
    .saxis_tvalid (saxis_tvalid),
    .saxis_tready (saxis_tready),
    .maxis_tdata  (maxis_tdata),
    .maxis_tvalid (maxis_tvalid),
    .maxis_tready (maxis_tready),
    .maxis_tlast  (maxis_tlast)
`ifdef STREAM_DOWNSIZER_STATS_EN
    ,
    .words_accepted (words_accepted),
    .slices_sent    (slices_sent)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [OUT_BITS-1:0] d;
    logic                l;
  } exp_t;

  exp_t                exp_q[$];
  int                  acc_cyc[$];
  int                  out_cyc[$];
  logic [OUT_BITS-1:0] out_dat[$];
  int                  n_cmp = 0;
  int                  n_err = 0;
  int                  cyc = 0;
  int                  n_out = 0;
  bit                  stop_sink = 0;
  logic                prev_stall = 1'b0;
  logic [OUT_BITS-1:0] prev_d = '0;
  logic                prev_l = 1'b0;
  exp_t                mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard: input handshakes push the LSB-first expansion, output handshakes pop and compare.
  always @(negedge clock) begin
    if (reset) begin
      check("tready_during_reset", saxis_tready, 0);
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (saxis_tvalid && saxis_tready) begin
        acc_cyc.push_back(cyc);
        for (int k = 0; k < RATIO; k++) begin
          mon_e.d = OUT_BITS'((saxis_tdata >> (OUT_BITS * k)) % (1 << OUT_BITS));
          mon_e.l = (k == RATIO - 1);
          exp_q.push_back(mon_e);
        end
      end
      if (prev_stall) begin
        check("stall_valid_held", maxis_tvalid, 1);
        check("stall_data_held", maxis_tdata, prev_d);
        check("stall_last_held", maxis_tlast, prev_l);
      end
      if (maxis_tvalid && maxis_tready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_slice: got %0h, expected no slice (cycle %0d)", maxis_tdata, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("slice_data", maxis_tdata, mon_e.d);
          check("slice_last", maxis_tlast, mon_e.l);
        end
        out_cyc.push_back(cyc);
        out_dat.push_back(maxis_tdata);
        n_out++;
      end
      prev_stall = maxis_tvalid && !maxis_tready;
      prev_d     = maxis_tdata;
      prev_l     = maxis_tlast;
    end
  end

  task automatic clear_logs();
    acc_cyc.delete();
    out_cyc.delete();
    out_dat.delete();
  endtask

  task automatic send_word(input logic [DATA_BITS-1:0] w);
    int t = 0;
    saxis_tdata  = w;
    saxis_tvalid = 1'b1;
    @(negedge clock);
    while (!saxis_tready && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (!saxis_tready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: word %0h not accepted, expected accept within 200 cycles", w);
    end
    @(posedge clock);
    #1;
    saxis_tvalid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic source_proc();
    int gap;
    int t;
    for (int i = 0; i < N_RAND; i++) begin
      gap = $urandom_range(0, 2);
      if (gap != 0) tick(gap);
      send_word($urandom);
    end
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      tick(1);
      t++;
    end
    stop_sink = 1;
  endtask

  task automatic sink_proc();
    int gap;
    while (!stop_sink) begin
      maxis_tready = 1'b1;
      tick(1);
      gap = $urandom_range(0, 2);
      if (gap != 0 && !stop_sink) begin
        maxis_tready = 1'b0;
        tick(gap);
      end
    end
    maxis_tready = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    saxis_tvalid = 1'b0;
    saxis_tdata  = '0;
    maxis_tready = 1'b0;

    // Reset held for 4 cycles
    repeat (4) begin
      @(negedge clock);
      check("rst_tvalid", maxis_tvalid, 0);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_tready", saxis_tready, 1);
    check("post_rst_tvalid", maxis_tvalid, 0);
    check("post_rst_tlast", maxis_tlast, 0);
    check("post_rst_tdata", maxis_tdata, 0);
`ifdef STREAM_DOWNSIZER_STATS_EN
    check("post_rst_words", words_accepted, 0);
    check("post_rst_slices", slices_sent, 0);
`endif

    // Single word, 1-cycle latency, 4 consecutive slices
    tick(1);
    maxis_tready = 1'b1;
    clear_logs();
    send_word(32'h44332211);
    tick(6);
    check("single_count", out_cyc.size(), 4);
    if (out_cyc.size() == 4 && acc_cyc.size() == 1) begin
      for (int k = 0; k < 4; k++) check("single_cycle", out_cyc[k], acc_cyc[0] + 1 + k);
    end

    // Back-to-back words, no bubble
    clear_logs();
    send_word(32'hA3A2A1A0);
    send_word(32'hB3B2B1B0);
    tick(10);
    check("b2b_count", out_cyc.size(), 8);
    if (out_cyc.size() == 8 && acc_cyc.size() == 2) begin
      for (int k = 1; k < 8; k++) check("b2b_cycle", out_cyc[k], out_cyc[0] + k);
      check("b2b_accept_with_A3", acc_cyc[1], out_cyc[3]);
      check("b2b_fourth_slice", out_dat[3], 8'hA3);
    end

    // Downstream stall while 0x22 is presented
    clear_logs();
    send_word(32'h44332211);
    tick(1);
    maxis_tready = 1'b0;
    saxis_tdata  = 32'h88776655;
    saxis_tvalid = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("stall_data", maxis_tdata, 8'h22);
      check("stall_last", maxis_tlast, 0);
      check("stall_valid", maxis_tvalid, 1);
      check("stall_in_tready", saxis_tready, 0);
    end
    @(posedge clock);
    #1;
    maxis_tready = 1'b1;
    send_word(32'h88776655);
    tick(8);
    check("stall_count", out_dat.size(), 8);

    // Reset in mid-word discards the remaining slices
    clear_logs();
    send_word(32'h44332211);
    tick(1);
    tick(1);
    maxis_tready = 1'b0;
    reset        = 1'b1;
    tick(1);
    reset = 1'b0;
    @(negedge clock);
    check("midrst_tvalid", maxis_tvalid, 0);
    tick(1);
    maxis_tready = 1'b1;
    send_word(32'h0D0C0B0A);
    tick(6);
    check("midrst_count", out_dat.size(), 6);
    if (out_dat.size() >= 3) check("midrst_first_new", out_dat[2], 8'h0A);

    // Randomized run with gaps on both sides
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    clear_logs();
    n_out = 0;
    fork
      source_proc();
      sink_proc();
    join
    tick(3);
    check("rand_queue_empty", exp_q.size(), 0);
    check("rand_words", acc_cyc.size(), N_RAND);
    check("rand_slices", n_out, N_RAND * RATIO);
`ifdef STREAM_DOWNSIZER_STATS_EN
    check("stats_words", words_accepted, N_RAND);
    check("stats_slices", slices_sent, N_RAND * RATIO);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
